ray_box_intersect: RTL and testbench

- Integer ray/axis-aligned-box intersection engine for the hardware ray tracer.
- Marches a fixed-point ray from an origin along a direction, one sub-step per clock, and reports the first step at which the ray point lies inside the box.
- Also reports the outward normal of the face that was entered.
- Free-running: it re-samples its inputs and restarts after every trace; no start or valid handshake.

---
 rtl/ray_pkg.sv | 48 ++++
 rtl/ray_axis_slab.sv | 72 +++++++
 rtl/ray_box_intersect.sv | 106 ++++++++++
 tb/tb_ray_box_intersect.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared field widths, bus layouts and defaults for the ray/box intersection engine.
package ray_pkg;
    localparam int OX_W = 10;
    localparam int OY_W = 10;
    localparam int OZ_W = 8;
    localparam int DX_W = 11;
    localparam int DY_W = 11;
    localparam int DZ_W = 9;

    localparam int TF_DEF     = 4;
    localparam int T_MISS_DEF = 1023;
    localparam int T_W        = 10;
    // 1023 steps of |dir|=1024 plus a 10-bit origin at TF=4 needs 22 bits; keep headroom.
    localparam int ACC_W      = 24;

    typedef struct packed {
        logic [OX_W-1:0] ox;
        logic [OY_W-1:0] oy;
        logic [OZ_W-1:0] oz;
    } origin_t;

    typedef struct packed {
        logic [DX_W-1:0] dx;
        logic [DY_W-1:0] dy;
        logic [DZ_W-1:0] dz;
    } dir_t;

    typedef struct packed {
        logic [OX_W-1:0] xmin;
        logic [OX_W-1:0] xmax;
        logic [OY_W-1:0] ymin;
        logic [OY_W-1:0] ymax;
        logic [OZ_W-1:0] zmin;
        logic [OZ_W-1:0] zmax;
    } box_t;

    typedef struct packed {
        logic [DX_W-1:0] nx;
        logic [DY_W-1:0] ny;
        logic [DZ_W-1:0] nz;
    } normal_t;

    typedef enum logic [1:0] {
        AX_BELOW = 2'd0,
        AX_IN    = 2'd1,
        AX_ABOVE = 2'd2
    } axis_st_e;
endpackage

// File: rtl/ray_axis_slab.sv
// One axis of the march: fixed-point accumulator, floor and slab compare,
// plus the below/in/above state from the previous step.
module ray_axis_slab
    import ray_pkg::*;
#(
    parameter int CW = 10,
    parameter int DW = 11,
    parameter int AW = ACC_W,
    parameter int TF = TF_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic          i_rec,
    input  logic [CW-1:0] i_org,
    input  logic [DW-1:0] i_dir,
    input  logic [CW-1:0] i_min,
    input  logic [CW-1:0] i_max,
    output logic          o_in,
    output axis_st_e      o_prev
);
    logic signed [AW-1:0] r_acc;
    logic        [DW-1:0] r_dir;
    logic        [CW-1:0] r_min;
    logic        [CW-1:0] r_max;
    axis_st_e             r_st;

    logic signed [AW-1:0] w_fl;
    logic signed [AW-1:0] w_dir_ext;
    logic signed [AW-1:0] w_min;
    logic signed [AW-1:0] w_max;
    axis_st_e             w_st;

    assign w_fl      = r_acc >>> TF;
    assign w_dir_ext = {{(AW-DW){r_dir[DW-1]}}, r_dir};
    assign w_min     = {{(AW-CW){1'b0}}, r_min};
    assign w_max     = {{(AW-CW){1'b0}}, r_max};

    // Bounds are non-negative, so a negative floor always lands in BELOW.
    always_comb begin
        w_st = AX_IN;
        if (w_fl < w_min)
            w_st = AX_BELOW;
        else if (w_fl > w_max)
            w_st = AX_ABOVE;
    end

    assign o_in   = (w_st == AX_IN);
    assign o_prev = r_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_dir <= '0;
            r_min <= '0;
            r_max <= '0;
            r_st  <= AX_BELOW;
        end else if (i_load) begin
            r_acc <= {{(AW-CW){1'b0}}, i_org} << TF;
            r_dir <= i_dir;
            r_min <= i_min;
            r_max <= i_max;
            r_st  <= AX_BELOW;
        end else begin
            if (i_step)
                r_acc <= r_acc + w_dir_ext;
            if (i_rec)
                r_st <= w_st;
        end
    end
endmodule

// File: rtl/ray_box_intersect.sv
// Free-running ray/box march: LOAD -> MARCH (one step per clock) -> DONE,
// reporting the first inside step and the outward normal of the entered face.
module ray_box_intersect
    import ray_pkg::*;
#(
    parameter int TF     = TF_DEF,
    parameter int T_MISS = T_MISS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] init,
    input  logic [30:0] dir,
    input  logic [55:0] object_in,
    output logic [9:0]  t_out,
    output logic [30:0] normal
);
    typedef enum logic [1:0] {S_LOAD, S_MARCH, S_DONE} state_e;

    state_e         r_state;
    logic [T_W-1:0] r_t;
    logic [T_W-1:0] r_res_t;
    normal_t        r_res_n;

    origin_t  w_org;
    dir_t     w_dir;
    box_t     w_box;
    normal_t  w_hit_n;
    logic     w_load, w_march, w_all_in, w_last, w_step;
    logic     w_in_x, w_in_y, w_in_z;
    axis_st_e w_prev_x, w_prev_y, w_prev_z;

    assign w_org    = init;
    assign w_dir    = dir;
    assign w_box    = object_in;
    assign w_load   = (r_state == S_LOAD);
    assign w_march  = (r_state == S_MARCH);
    assign w_all_in = w_in_x & w_in_y & w_in_z;
    assign w_last   = (r_t == T_W'(T_MISS - 1));
    assign w_step   = w_march & ~w_all_in & ~w_last;

    ray_axis_slab #(.CW(OX_W), .DW(DX_W), .AW(ACC_W), .TF(TF)) u_slab_x (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step), .i_rec(w_march),
        .i_org(w_org.ox), .i_dir(w_dir.dx), .i_min(w_box.xmin), .i_max(w_box.xmax),
        .o_in(w_in_x), .o_prev(w_prev_x)
    );
    ray_axis_slab #(.CW(OY_W), .DW(DY_W), .AW(ACC_W), .TF(TF)) u_slab_y (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step), .i_rec(w_march),
        .i_org(w_org.oy), .i_dir(w_dir.dy), .i_min(w_box.ymin), .i_max(w_box.ymax),
        .o_in(w_in_y), .o_prev(w_prev_y)
    );
    ray_axis_slab #(.CW(OZ_W), .DW(DZ_W), .AW(ACC_W), .TF(TF)) u_slab_z (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step), .i_rec(w_march),
        .i_org(w_org.oz), .i_dir(w_dir.dz), .i_min(w_box.zmin), .i_max(w_box.zmax),
        .o_in(w_in_z), .o_prev(w_prev_z)
    );

    // Entered face: first axis (x > y > z) that was outside on the previous step.
    always_comb begin
        w_hit_n = '0;
        if (r_t != '0) begin
            if (w_prev_x != AX_IN)
                w_hit_n.nx = (w_prev_x == AX_BELOW) ? {DX_W{1'b1}} : DX_W'(1);
            else if (w_prev_y != AX_IN)
                w_hit_n.ny = (w_prev_y == AX_BELOW) ? {DY_W{1'b1}} : DY_W'(1);
            else if (w_prev_z != AX_IN)
                w_hit_n.nz = (w_prev_z == AX_BELOW) ? {DZ_W{1'b1}} : DZ_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
            r_t     <= '0;
            r_res_t <= T_W'(T_MISS);
            r_res_n <= '0;
            t_out   <= T_W'(T_MISS);
            normal  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_t     <= '0;
                    r_state <= S_MARCH;
                end
                S_MARCH: begin
                    if (w_all_in) begin
                        r_res_t <= r_t;
                        r_res_n <= w_hit_n;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        r_res_t <= T_W'(T_MISS);
                        r_res_n <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                S_DONE: begin
                    t_out   <= r_res_t;
                    normal  <= r_res_n;
                    r_state <= S_LOAD;
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_box_intersect.sv
// Bench for ray_box_intersect: directed spec cases plus random rays against a
// closed-form point(t) = origin + t*dir/16 reference.
module tb_ray_box_intersect;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [27:0] init = '0;
    logic [30:0] dir = '0;
    logic [55:0] object_in = '0;
    logic [9:0]  t_out;
    logic [30:0] normal;

    int total = 0;
    int bad   = 0;

    localparam logic [55:0] BOX = {10'd16, 10'd32, 10'd20, 10'd36, 8'd0, 8'd30};
    localparam logic [30:0] D_TIE = {11'd16, 11'd20, 9'd3};

    always #5 clk = ~clk;

    ray_box_intersect dut (
        .clk(clk), .rst(rst), .init(init), .dir(dir),
        .object_in(object_in), .t_out(t_out), .normal(normal)
    );

    // Reference: evaluate each step directly from origin + t*dir, no accumulation.
    function automatic void ref_model(input logic [27:0] o, input logic [30:0] d,
                                      input logic [55:0] b, output int rt,
                                      output logic [30:0] rn);
        int po[3], dv[3], lo[3], hi[3], ps[3], cs[3];
        logic [10:0] nx, ny;
        logic [8:0]  nz;
        bit found, all_in, picked;
        po[0] = int'(o[27:18]); po[1] = int'(o[17:8]); po[2] = int'(o[7:0]);
        dv[0] = int'($signed(d[30:20])); dv[1] = int'($signed(d[19:9])); dv[2] = int'($signed(d[8:0]));
        lo[0] = int'(b[55:46]); hi[0] = int'(b[45:36]);
        lo[1] = int'(b[35:26]); hi[1] = int'(b[25:16]);
        lo[2] = int'(b[15:8]);  hi[2] = int'(b[7:0]);
        rt = 1023; nx = '0; ny = '0; nz = '0;
        found = 1'b0;
        for (int a = 0; a < 3; a++) ps[a] = 0;
        for (int t = 0; t < 1023 && !found; t++) begin
            all_in = 1'b1;
            for (int a = 0; a < 3; a++) begin
                int fl;
                fl = (po[a] * 16 + t * dv[a]) >>> 4;
                cs[a] = (fl < lo[a]) ? -1 : ((fl > hi[a]) ? 1 : 0);
                if (cs[a] != 0) all_in = 1'b0;
            end
            if (all_in) begin
                found = 1'b1;
                rt = t;
                picked = 1'b0;
                if (t > 0) begin
                    for (int a = 0; a < 3; a++) begin
                        if (!picked && ps[a] != 0) begin
                            picked = 1'b1;
                            if (a == 0) nx = (ps[a] < 0) ? 11'h7FF : 11'd1;
                            if (a == 1) ny = (ps[a] < 0) ? 11'h7FF : 11'd1;
                            if (a == 2) nz = (ps[a] < 0) ? 9'h1FF : 9'd1;
                        end
                    end
                end
            end
            for (int a = 0; a < 3; a++) ps[a] = cs[a];
        end
        rn = {nx, ny, nz};
    endfunction

    // Reset, apply inputs, release; sample one cycle before and at the result edge.
    task automatic do_trace(input logic [27:0] o, input logic [30:0] d, input logic [55:0] b,
                            input int lat, output logic [9:0] t_e, output logic [30:0] n_e,
                            output logic [9:0] t_g, output logic [30:0] n_g);
        @(negedge clk);
        rst = 1'b0; init = o; dir = d; object_in = b;
        @(negedge clk);
        rst = 1'b1;
        repeat (lat - 1) @(posedge clk);
        #1; t_e = t_out; n_e = normal;
        @(posedge clk);
        #1; t_g = t_out; n_g = normal;
    endtask

    task automatic test_reset();
        init = 28'hFFFFFFF; dir = '1; object_in = '1; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (t_out !== 10'd1023) begin bad++; $display("FAIL reset_t got=%0d want=1023", t_out); end
        total++;
        if (normal !== 31'd0) begin bad++; $display("FAIL reset_n got=%h want=0", normal); end
    endtask

    task automatic test_directed();
        logic [27:0] c_o[5];
        logic [30:0] c_d[5];
        logic [9:0]  c_t[5];
        logic [30:0] c_n[5];
        logic [9:0]  t_e, t_g;
        logic [30:0] n_e, n_g;
        int lat;
        c_o = '{28'd0, {10'd20, 10'd25, 8'd5}, 28'd0, {10'd100, 10'd25, 8'd5}, {10'd20, 10'd25, 8'd40}};
        c_d = '{D_TIE, D_TIE, {11'd0, 11'd0, 9'd1}, {11'h7F0, 11'd0, 9'd0}, {11'd0, 11'd0, 9'h1F0}};
        c_t = '{10'd16, 10'd0, 10'd1023, 10'd68, 10'd10};
        c_n = '{{11'h7FF, 11'd0, 9'd0}, 31'd0, 31'd0, {11'd1, 11'd0, 9'd0}, {11'd0, 11'd0, 9'd1}};
        for (int i = 0; i < 5; i++) begin
            lat = (c_t[i] == 10'd1023) ? 1025 : int'(c_t[i]) + 3;
            do_trace(c_o[i], c_d[i], BOX, lat, t_e, n_e, t_g, n_g);
            total++;
            if (t_e !== 10'd1023 || n_e !== 31'd0) begin
                bad++; $display("FAIL dir%0d_early got t=%0d n=%h want t=1023 n=0", i, t_e, n_e);
            end
            total++;
            if (t_g !== c_t[i]) begin bad++; $display("FAIL dir%0d_t got=%0d want=%0d", i, t_g, c_t[i]); end
            total++;
            if (n_g !== c_n[i]) begin bad++; $display("FAIL dir%0d_n got=%h want=%h", i, n_g, c_n[i]); end
        end
    endtask

    task automatic test_random();
        logic [27:0] o;
        logic [30:0] d;
        logic [55:0] b;
        logic [9:0]  t_e, t_g;
        logic [30:0] n_e, n_g, en;
        int et, xl, yl, zl, xh, yh, zh;
        for (int i = 0; i < 12; i++) begin
            xl = $urandom_range(0, 300); xh = xl + $urandom_range(0, 300); if (xh > 1023) xh = 1023;
            yl = $urandom_range(0, 300); yh = yl + $urandom_range(0, 300); if (yh > 1023) yh = 1023;
            zl = $urandom_range(0, 100); zh = zl + $urandom_range(0, 120); if (zh > 255) zh = 255;
            b = {xl[9:0], xh[9:0], yl[9:0], yh[9:0], zl[7:0], zh[7:0]};
            o = {10'($urandom_range(0, 700)), 10'($urandom_range(0, 700)), 8'($urandom_range(0, 255))};
            d = {11'($urandom_range(0, 160) - 80), 11'($urandom_range(0, 160) - 80), 9'($urandom_range(0, 64) - 32)};
            ref_model(o, d, b, et, en);
            do_trace(o, d, b, (et == 1023) ? 1025 : et + 3, t_e, n_e, t_g, n_g);
            total++;
            if (t_g !== 10'(et)) begin bad++; $display("FAIL rnd%0d_t got=%0d want=%0d", i, t_g, et); end
            total++;
            if (n_g !== en) begin bad++; $display("FAIL rnd%0d_n got=%h want=%h", i, n_g, en); end
            total++;
            if (t_e !== 10'd1023) begin bad++; $display("FAIL rnd%0d_early got=%0d want=1023", i, t_e); end
        end
    endtask

    // Inputs change mid-march and must only affect the following trace.
    task automatic test_back_to_back();
        @(negedge clk);
        rst = 1'b0; init = 28'd0; dir = D_TIE; object_in = BOX;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; init = {10'd100, 10'd25, 8'd5}; dir = {11'h7F0, 11'd0, 9'd0};
        repeat (17) @(posedge clk);
        #1;
        total++;
        if (t_out !== 10'd16 || normal !== {11'h7FF, 11'd0, 9'd0}) begin
            bad++; $display("FAIL b2b_first got t=%0d n=%h want t=16 n=%h", t_out, normal, {11'h7FF, 11'd0, 9'd0});
        end
        repeat (70) @(posedge clk);
        #1;
        total++;
        if (t_out !== 10'd16) begin bad++; $display("FAIL b2b_hold got=%0d want=16", t_out); end
        @(posedge clk);
        #1;
        total++;
        if (t_out !== 10'd68 || normal !== {11'd1, 11'd0, 9'd0}) begin
            bad++; $display("FAIL b2b_second got t=%0d n=%h want t=68 n=%h", t_out, normal, {11'd1, 11'd0, 9'd0});
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0]  t_e, t_g;
        logic [30:0] n_e, n_g;
        do_trace(28'd0, D_TIE, BOX, 19, t_e, n_e, t_g, n_g);
        total++;
        if (t_g !== 10'd16) begin bad++; $display("FAIL rmid_pre got=%0d want=16", t_g); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (t_out !== 10'd1023 || normal !== 31'd0) begin
            bad++; $display("FAIL rmid_async got t=%0d n=%h want t=1023 n=0", t_out, normal);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        total++;
        if (t_out !== 10'd16 || normal !== {11'h7FF, 11'd0, 9'd0}) begin
            bad++; $display("FAIL rmid_restart got t=%0d n=%h want t=16", t_out, normal);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
